// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one unified memory between the core (port 0)
// and a DMA/loader engine (port 1), with wait-state tolerance and ack timeout.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            req0_i,
    input  logic            req1_i,
    input  logic            we0_i,
    input  logic            we1_i,
    input  logic [AW-1:0]   addr0_i,
    input  logic [AW-1:0]   addr1_i,
    input  logic [DW-1:0]   wdata0_i,
    input  logic [DW-1:0]   wdata1_i,
    input  logic [DW/8-1:0] wmask0_i,
    input  logic [DW/8-1:0] wmask1_i,
    output logic            done0_o,
    output logic            done1_o,
    output logic            err0_o,
    output logic            err1_o,
    output logic [DW-1:0]   rdata0_o,
    output logic [DW-1:0]   rdata1_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_wmask_o,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    logic            pick;
    logic            capture;
    logic [DW-1:0]   capture_val;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [DW/8-1:0] sel_wmask;
    logic [1:0]      done_v;
    logic [1:0]      err_v;

    // On a tie the port that did not win last time gets the grant.
    assign pick = (req0_i && req1_i) ? ~last_q : req1_i;

    assign sel_we    = owner_q ? we1_i    : we0_i;
    assign sel_addr  = owner_q ? addr1_i  : addr0_i;
    assign sel_wdata = owner_q ? wdata1_i : wdata0_i;
    assign sel_wmask = owner_q ? wmask1_i : wmask0_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        capture     = 1'b0;
        capture_val = '0;
        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = 8'd0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // An ack in the final allowed cycle still beats the timeout.
                if (mem_ack_i) begin
                    capture     = 1'b1;
                    capture_val = sel_we ? '0 : mem_rdata_i;
                    err_d       = 1'b0;
                    state_d     = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    capture     = 1'b1;
                    capture_val = '0;
                    err_d       = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DW-1:0] rdata_q;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                rdata_q <= '0;
            end else if (capture && (owner_q == 1'(gi))) begin
                rdata_q <= capture_val;
            end
        end

        assign done_v[gi] = (state_q == S_DONE) && (owner_q == 1'(gi));
        assign err_v[gi]  = done_v[gi] && err_q;
    end

    assign done0_o  = done_v[0];
    assign done1_o  = done_v[1];
    assign err0_o   = err_v[0];
    assign err1_o   = err_v[1];
    assign rdata0_o = g_port[0].rdata_q;
    assign rdata1_o = g_port[1].rdata_q;

    assign mem_req_o   = (state_q == S_GRANT);
    assign mem_we_o    = mem_req_o && sel_we;
    assign mem_addr_o  = mem_req_o ? sel_addr  : '0;
    assign mem_wdata_o = mem_req_o ? sel_wdata : '0;
    assign mem_wmask_o = mem_req_o ? sel_wmask : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single unified instruction/data memory of the multicycle RISC-V core between the core (port 0) and a DMA/loader engine (port 1). It performs round-robin arbitration, a request/done handshake per port and a wait-state-tolerant handshake to memory. A timeout aborts transactions that memory never acknowledges. It sits between the core's memory interface and the memory model/controller.

## Interface

- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 15, max cycles mem_req may stay high without mem_ack before abort (1..255)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transaction request; held high with we/addr/wdata/wmask stable until doneN
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  byte address
- wdata0 / wdata1  in  DW  write data
- wmask0 / wmask1  in  DW/8  byte write enables
- done0 / done1  out  1  one-cycle completion pulse
- err0 / err1  out  1  high with doneN when transaction timed out
- rdata0 / rdata1  out  DW  registered read data, valid while doneN high
- mem_req  out  1  memory access request
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/AW/DW/DW/8  owner's fields; all zero when mem_req = 0
- mem_rdata  in  DW  memory read data, sampled when mem_ack = 1
- mem_ack  in  1  memory completion, one cycle

## Operation

- States: IDLE, GRANT, DONE. Registers: owner (1 bit), last (1 bit, last granted port), wait counter (8 bits), rdata0/1, err flag.
- IDLE: if only reqN high -> owner = N, go GRANT. If both high -> owner = ~last. Neither -> stay. On entering GRANT, last <= owner, counter <= 0.
- GRANT: mem_req = 1; mem_we/addr/wdata/wmask = owner's inputs (combinational mux on owner). If mem_ack: rdata_owner <= mem_rdata (writes: rdata_owner <= 0), err <= 0, go DONE. Else if counter == TIMEOUT-1: rdata_owner <= 0, err <= 1, go DONE. Else counter++.
- mem_ack and timeout in the same cycle: ack wins (err = 0, data captured).
- DONE: done_owner = 1, err_owner = err; mem_req = 0; always go IDLE. Requests are not sampled in DONE.
- Non-owner rdata holds its previous value; doneN/errN of non-owner = 0.
- Owner dropping reqN during GRANT is illegal; arbiter completes the access regardless.
- mem_ack in IDLE or DONE is ignored.
- Reset (async, any state): state = IDLE, owner = 0, last = 1 (port 0 wins first tie), counter = 0, err = 0, rdata0 = rdata1 = 0. Thus immediately: mem_req = 0, all mem_* fields 0, done0/1 = 0, err0/1 = 0.

## Timing

- Request seen in IDLE at edge k -> mem_req high from cycle k+1.
- mem_ack at cycle k+1+w (w wait states, w < TIMEOUT) -> doneN high in cycle k+2+w -> IDLE at k+3+w.
- Minimum: 3 cycles per transaction (IDLE, GRANT, DONE); requester holding reqN high after done is re-arbitrated in the IDLE cycle.
- Timeout: mem_req high exactly TIMEOUT cycles, then doneN+errN for one cycle.
- Continuous contention: grants strictly alternate 0,1,0,1...; no port waits more than one transaction.
- All outputs except the mem_* field mux are registered-state decodes; no combinational path from mem_ack to doneN.

## Test plan

- Port 0 read, addr0 = 0x00000010, mem_ack in first GRANT cycle with mem_rdata = 0xDEADBEEF -> mem_req high 1 cycle, done0 pulse 1 cycle later, rdata0 = 0xDEADBEEF, err0 = 0, done1 = 0.
- Port 1 write addr1 = 0x00000200, wdata1 = 0x12345678, wmask1 = 0xF, mem_ack after 3 wait states -> mem_req high 4 cycles with mem_we = 1 and those fields, done1 pulse, mem_* zero afterward.
- req0 and req1 both held high from reset release, zero wait states -> grant order 0,1,0,1, each done 3 cycles apart; rdata of each port tracks only its own accesses.
- Port 0 read, mem_ack never asserted, TIMEOUT = 15 -> mem_req high exactly 15 cycles, done0 = err0 = 1 for one cycle, rdata0 = 0; then mem_ack arriving at TIMEOUT-th cycle instead -> err0 = 0, data captured.
- reset_n pulled low mid-GRANT (no clock edge) -> mem_req, mem_addr, done0/1, err0/1 go 0 immediately; after release with both requests pending, port 0 granted first.
- mem_ack pulsed while IDLE and while DONE -> no state change, no spurious done.
